// File: rtl/chufa_fp32.sv
// Sequential FP32 divider S = A / B: restoring mantissa division, one quotient bit per clock.
// Define CHUFA_ROUND_EN for round-to-nearest-even; the default build truncates.
module chufa_fp32 #(
    parameter int unsigned QBITS = 26
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] S,
    output logic        div_by_zero
);
    localparam int unsigned CW = $clog2(QBITS + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DIV, ST_NORM, ST_DONE} state_t;

    state_t            r_state;
    logic [CW-1:0]     r_count;
    logic              r_sign;
    logic [7:0]        r_exp_a;
    logic [7:0]        r_exp_b;
    logic [23:0]       r_man_b;
    logic [24:0]       r_rem;
    logic [QBITS-1:0]  r_q;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [31:0]       r_s;
    logic              r_dz;

    logic              w_ge;
    logic [24:0]       w_diff;
    logic signed [9:0] w_e;
    logic [22:0]       w_mant;
    logic              w_guard;
    logic              w_sticky;
    logic [23:0]       w_sum;
    logic [31:0]       w_res;
    logic              w_dz;
    logic              w_za, w_zb, w_ia, w_ib;

    always_comb begin
        w_ge   = (r_rem >= {1'b0, r_man_b});
        w_diff = r_rem - {1'b0, r_man_b};
    end

    // Mantissa/guard positions assume QBITS = 26 (1 integer + 23 fraction + 2 guard).
    always_comb begin
        w_e   = $signed({2'b00, r_exp_a}) - $signed({2'b00, r_exp_b}) + 10'sd127;
        w_sum = '0;
        if (r_q[QBITS-1]) begin
            w_mant   = r_q[QBITS-2 -: 23];
            w_guard  = r_q[1];
            w_sticky = (r_rem != '0) | r_q[0];
        end else begin
            w_mant   = r_q[QBITS-3 -: 23];
            w_guard  = r_q[0];
            w_sticky = (r_rem != '0);
            w_e      = w_e - 10'sd1;
        end
`ifdef CHUFA_ROUND_EN
        if (w_guard && (w_sticky || w_mant[0])) begin
            w_sum  = {1'b0, w_mant} + 24'd1;
            w_mant = w_sum[22:0];
            if (w_sum[23])
                w_e = w_e + 10'sd1;
        end
`endif
        w_za = (r_exp_a == 8'h00);
        w_zb = (r_exp_b == 8'h00);
        w_ia = (r_exp_a == 8'hFF);
        w_ib = (r_exp_b == 8'hFF);
        w_dz = 1'b0;
        if (w_e >= 10'sd255)
            w_res = {r_sign, 8'hFF, 23'h0};
        else if (w_e <= 10'sd0)
            w_res = {r_sign, 31'h0};
        else
            w_res = {r_sign, w_e[7:0], w_mant};
        // Special operands override the arithmetic path, highest priority first.
        if ((w_za && w_zb) || (w_ia && w_ib)) begin
            w_res = 32'h7FC00000;
        end else if (w_ia || w_zb) begin
            w_res = {r_sign, 8'hFF, 23'h0};
            w_dz  = !w_ia && !w_za;
        end else if (w_za || w_ib) begin
            w_res = {r_sign, 31'h0};
        end
    end

`ifndef CHUFA_ROUND_EN
    logic w_unused_rnd;
    assign w_unused_rnd = w_guard | w_sticky | (|w_sum);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_sign      <= 1'b0;
            r_exp_a     <= '0;
            r_exp_b     <= '0;
            r_man_b     <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_s         <= '0;
            r_dz        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_sign     <= A[31] ^ B[31];
                        r_exp_a    <= A[30:23];
                        r_exp_b    <= B[30:23];
                        r_man_b    <= {1'b1, B[22:0]};
                        r_rem      <= {2'b01, A[22:0]};
                        r_q        <= '0;
                        r_count    <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (w_ge) begin
                        r_rem <= {w_diff[23:0], 1'b0};
                        r_q   <= {r_q[QBITS-2:0], 1'b1};
                    end else begin
                        r_rem <= {r_rem[23:0], 1'b0};
                        r_q   <= {r_q[QBITS-2:0], 1'b0};
                    end
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(QBITS - 1))
                        r_state <= ST_NORM;
                end
                ST_NORM: begin
                    r_s         <= w_res;
                    r_dz        <= w_dz;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign S           = r_s;
    assign div_by_zero = r_dz;
endmodule

// File: tb/tb_chufa_fp32.sv
// Self-checking bench for chufa_fp32: directed cases, back-pressure, mid-op reset and random
// operands checked against an integer-division reference model.
module tb_chufa_fp32;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] S;
    logic        div_by_zero;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    chufa_fp32 #(.QBITS(26)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .S(S), .div_by_zero(div_by_zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: exact quotient of the mantissas scaled by 2^25, then IEEE packing rules.
    function automatic logic [32:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, e;
        longint unsigned ma, mb, num, q, r, mant;
        bit g, st, za, zb, ia, ib, rnd_en;
`ifdef CHUFA_ROUND_EN
        rnd_en = 1;
`else
        rnd_en = 0;
`endif
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        za = (ea == 0); zb = (eb == 0); ia = (ea == 255); ib = (eb == 255);
        if ((za && zb) || (ia && ib)) return {1'b0, 32'h7FC00000};
        if (ia || zb) return {!ia && !za, s, 8'hFF, 23'h0};
        if (za || ib) return {1'b0, s, 31'h0};
        ma  = 64'h800000 | longint'(a[22:0]);
        mb  = 64'h800000 | longint'(b[22:0]);
        num = ma << 25;
        q   = num / mb;
        r   = num % mb;
        e   = ea - eb + 127;
        if (q >= (64'd1 << 25)) begin
            mant = (q >> 2) & 64'h7FFFFF;
            g    = q[1];
            st   = q[0] || (r != 0);
        end else begin
            mant = (q >> 1) & 64'h7FFFFF;
            g    = q[0];
            st   = (r != 0);
            e    = e - 1;
        end
        if (rnd_en && g && (st || mant[0])) begin
            mant = mant + 1;
            if (mant == (64'd1 << 23)) begin
                mant = 0;
                e    = e + 1;
            end
        end
        if (e >= 255) return {1'b0, s, 8'hFF, 23'h0};
        if (e <= 0) return {1'b0, s, 31'h0};
        return {1'b0, s, e[7:0], mant[22:0]};
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_s, input logic exp_dz, input int hold);
        int lat;
        @(negedge clk);
        chk({tag, ".in_ready"}, {31'h0, in_ready}, 32'd1);
        A = a; B = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; A = $urandom; B = $urandom;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, 32'd27);
        chk({tag, ".S"}, S, exp_s);
        chk({tag, ".dz"}, {31'h0, div_by_zero}, {31'h0, exp_dz});
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1; A = $urandom; B = $urandom;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk({tag, ".hold_S"}, S, exp_s);
            chk({tag, ".hold_dz"}, {31'h0, div_by_zero}, {31'h0, exp_dz});
            chk({tag, ".hold_valid"}, {31'h0, out_valid}, 32'd1);
            chk({tag, ".hold_in_ready"}, {31'h0, in_ready}, 32'd0);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        chk({tag, ".post_valid"}, {31'h0, out_valid}, 32'd0);
        chk({tag, ".post_in_ready"}, {31'h0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [32:0] ref_v;
        logic [31:0] ra, rb, third;
`ifdef CHUFA_ROUND_EN
        third = 32'h3EAAAAAB;
`else
        third = 32'h3EAAAAAA;
`endif
        #2 rst_n = 1'b0;
        #5;
        chk("reset.S", S, 32'h0);
        chk("reset.out_valid", {31'h0, out_valid}, 32'd0);
        chk("reset.dz", {31'h0, div_by_zero}, 32'd0);
        chk("reset.in_ready", {31'h0, in_ready}, 32'd1);
        @(negedge clk); rst_n = 1'b1;

        run_op("6/2", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 0);
        run_op("1/3", 32'h3F800000, 32'h40400000, third, 1'b0, 0);
        run_op("-1.5/0.5", 32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0, 0);
        run_op("1/0", 32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 0);
        run_op("0/0", 32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 0);
        run_op("inf/inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 0);
        run_op("inf/0", 32'hFF800000, 32'h00000000, 32'hFF800000, 1'b0, 0);
        run_op("0/inf", 32'h80000000, 32'h7F800000, 32'h80000000, 1'b0, 0);
        run_op("ovf", 32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 0);
        run_op("uflow", 32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 0);
        run_op("bp", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 5);
        run_op("after_bp", 32'h3F800000, 32'h40400000, third, 1'b0, 0);

        // Abort in the middle of the division.
        @(negedge clk);
        A = 32'h3F800000; B = 32'h40400000; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid.out_valid", {31'h0, out_valid}, 32'd0);
        chk("rst_mid.in_ready", {31'h0, in_ready}, 32'd1);
        chk("rst_mid.S", S, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        run_op("after_rst", 32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 0);

        for (int i = 0; i < 24; i++) begin
            if (i < 16) begin
                ra = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
                rb = {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
            end else begin
                ra = $urandom;
                rb = $urandom;
            end
            ref_v = ref_div(ra, rb);
            run_op($sformatf("rnd%0d", i), ra, rb, ref_v[31:0], ref_v[32], int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
